// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
// The counter width holds 0..DEPTH inclusive, one bit wider than the pointers.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Write/read/status bundle between a producer/consumer pair and sync_fifo_prog.
// The master side drives requests and thresholds; the FIFO (slave) drives data and status.
interface sync_fifo_prog_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic                  w_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  full;
  logic                  almost_full;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;
  logic [CNT_W-1:0]      count;
  logic                  clr_err;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, w_data, r_en, af_thresh, ae_thresh, clr_err,
    input  full, almost_full, r_data, r_valid, empty, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  w_en, w_data, r_en, af_thresh, ae_thresh, clr_err,
    output full, almost_full, r_data, r_valid, empty, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_2p.sv
// Storage array for the FIFO: synchronous write port, asynchronous read port.
// Intentionally unreset so it maps onto plain flops or a register file.
module fifo_mem_2p #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// fill level, sticky overflow/underflow flags and selectable standard/FWFT read.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_prog_if.slave bus
);

  localparam int                CNT_W    = cnt_width(DEPTH);
  localparam int                PTR_W    = $clog2(DEPTH);
  localparam fifo_mode_e        MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  is_full;
  logic                  is_empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  overflow_q;
  logic                  underflow_q;

  // Flags come only from the count register, so request inputs never reach them combinationally.
  assign is_full  = (count_q == CNT_FULL);
  assign is_empty = (count_q == '0);
  assign wr_acc   = bus.w_en && !is_full;
  assign rd_acc   = bus.r_en && !is_empty;

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.w_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky errors: a new offending attempt wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.w_en && is_full) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_q <= 1'b0;
      end
      if (bus.r_en && is_empty) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (count_q >= bus.af_thresh);
  assign bus.almost_empty = (count_q <= bus.ae_thresh);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      assign bus.r_data  = mem_rdata;
      assign bus.r_valid = !is_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_data_q;
      logic                  r_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data_q  <= '0;
          r_valid_q <= 1'b0;
        end else begin
          r_valid_q <= rd_acc;
          if (rd_acc) begin
            r_data_q <= mem_rdata;
          end
        end
      end

      assign bus.r_data  = r_data_q;
      assign bus.r_valid = r_valid_q;
    end
  endgenerate

endmodule
